// File: rtl/rc5_decryptor.sv
// RC5 block decryptor that walks the expanded-key table from S[T-1] down to S[0].
// The table is read through a one-cycle-latency synchronous RAM port.
module rc5_decryptor #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int T = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    input  logic [W-1:0]         iA,
    input  logic [W-1:0]         iB,
    output logic [$clog2(T)-1:0] oS_address,
    input  logic [W-1:0]         iS_sub_i,
    output logic [W-1:0]         oA,
    output logic [W-1:0]         oB,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int AW = $clog2(T);
    localparam int SW = $clog2(W);

    if (T != 2 * R + 2) begin : g_param_check
        $error("rc5_decryptor: T must equal 2*R+2");
    end

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        SUB,
        ROTX,
        FINAL_SUB,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   tmp;
    logic [AW-1:0]  k;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [SW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} >> n;
        return d[W-1:0];
    endfunction

    // Odd key indices update B, even ones update A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            tmp        <= '0;
            k          <= AW'(T - 1);
            oS_address <= AW'(T - 1);
            oA         <= '0;
            oB         <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        a     <= iA;
                        b     <= iB;
                        k     <= AW'(T - 1);
                        oBusy <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    oS_address <= k;
                    state      <= WAIT;
                end
                WAIT: begin
                    state <= (k >= AW'(2)) ? SUB : FINAL_SUB;
                end
                SUB: begin
                    tmp   <= (k[0] ? b : a) - iS_sub_i;
                    state <= ROTX;
                end
                ROTX: begin
                    if (k[0]) begin
                        b <= rotr(tmp, a[SW-1:0]) ^ a;
                    end else begin
                        a <= rotr(tmp, b[SW-1:0]) ^ b;
                    end
                    k     <= k - AW'(1);
                    state <= ADDR;
                end
                FINAL_SUB: begin
                    if (k[0]) begin
                        b <= b - iS_sub_i;
                    end else begin
                        a <= a - iS_sub_i;
                    end
                    if (k == '0) begin
                        state <= DONE;
                    end else begin
                        k     <= k - AW'(1);
                        state <= ADDR;
                    end
                end
                DONE: begin
                    oA    <= a;
                    oB    <= b;
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_decryptor.sv
// Directed bench for rc5_decryptor: key-table RAM model, latency, address order,
// busy-start immunity and mid-operation reset.
module tb_rc5_decryptor;

    logic        clk;
    logic        rst;
    logic        iStart;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [4:0]  oS_address;
    logic [31:0] iS_sub_i;
    logic [31:0] oA;
    logic [31:0] oB;
    logic        oBusy;
    logic        oDone;

    logic [31:0] s_mem [32];
    logic [4:0]  addr_q [$];
    logic        rec;
    int          done_cnt;
    int          n_vec;
    int          n_err;

    rc5_decryptor dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iA         (iA),
        .iB         (iB),
        .oS_address (oS_address),
        .iS_sub_i   (iS_sub_i),
        .oA         (oA),
        .oB         (oB),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read key RAM
    always @(posedge clk) iS_sub_i <= s_mem[oS_address];

    always @(negedge clk) begin
        if (oDone === 1'b1) done_cnt++;
        if (rec && oBusy) addr_q.push_back(oS_address);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    // RC5-32/12 key expansion of a 16-byte all-zero key
    task automatic load_zero_key_table();
        logic [31:0] l [4];
        logic [31:0] ka;
        logic [31:0] kb;
        int i;
        int j;
        s_mem[0] = 32'hB7E15163;
        for (int n = 1; n < 26; n++) s_mem[n] = s_mem[n-1] + 32'h9E3779B9;
        for (int n = 0; n < 4; n++) l[n] = '0;
        ka = '0;
        kb = '0;
        i = 0;
        j = 0;
        for (int n = 0; n < 78; n++) begin
            ka = rotl(s_mem[i] + ka + kb, 5'd3);
            s_mem[i] = ka;
            kb = rotl(l[j] + ka + kb, 5'(ka + kb));
            l[j] = kb;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic encrypt(input logic [31:0] pa, input logic [31:0] pb,
                           output logic [31:0] ca, output logic [31:0] cb);
        ca = pa + s_mem[0];
        cb = pb + s_mem[1];
        for (int i = 1; i <= 12; i++) begin
            ca = rotl(ca ^ cb, cb[4:0]) + s_mem[2*i];
            cb = rotl(cb ^ ca, ca[4:0]) + s_mem[2*i+1];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Caller is away from a clock edge; returns #1 after the sampling edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        iA = a;
        iB = b;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        check_eq("busy_after_start", 32'(oBusy), 32'd1);
    endtask

    // poke_kind: 0 none, 1 extra start pulse, 2 reset pulse at edge poke_cycle
    task automatic wait_done(input int budget, input int poke_cycle, input int poke_kind,
                             output int lat);
        lat = 0;
        for (int n = 1; n <= budget; n++) begin
            if (n == poke_cycle && poke_kind == 1) begin
                iA = 32'hDEADBEEF;
                iB = 32'h0BADF00D;
                iStart = 1'b1;
            end
            if (n == poke_cycle && poke_kind == 2) rst = 1'b1;
            @(posedge clk);
            #1;
            iStart = 1'b0;
            rst = 1'b0;
            if (oDone === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] c1a, c1b, c2a, c2b;
        int lat;
        int d0;
        int runs;
        int bad;
        int len;
        logic [4:0] prev;

        n_vec = 0;
        n_err = 0;
        done_cnt = 0;
        rec = 1'b0;
        rst = 1'b0;
        iStart = 1'b0;
        iA = '0;
        iB = '0;
        for (int n = 0; n < 32; n++) s_mem[n] = '0;

        do_reset();
        check_eq("rst_oA", oA, 32'h0);
        check_eq("rst_oB", oB, 32'h0);
        check_eq("rst_done", 32'(oDone), 32'd0);
        check_eq("rst_busy", 32'(oBusy), 32'd0);
        check_eq("rst_addr", 32'(oS_address), 32'd25);

        // All-zero key table, with address trace
        rec = 1'b1;
        start_op(32'h0, 32'h0);
        wait_done(150, 0, 0, lat);
        rec = 1'b0;
        check_eq("zero_lat", lat, 103);
        check_eq("zero_oA", oA, 32'h0);
        check_eq("zero_oB", oB, 32'h0);
        runs = 0;
        bad = 0;
        len = 0;
        prev = '0;
        foreach (addr_q[i]) begin
            if (i == 0 || addr_q[i] != prev) begin
                if (i != 0 && len < 2) bad++;
                if (addr_q[i] != 5'(25 - runs)) bad++;
                runs++;
                prev = addr_q[i];
                len = 1;
            end else begin
                len++;
            end
        end
        if (len < 2) bad++;
        check_eq("addr_runs", runs, 26);
        check_eq("addr_order", bad, 0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(oDone), 32'd0);
        check_eq("busy_cleared", 32'(oBusy), 32'd0);

        // Published RC5-32/12/16 zero-key vector
        load_zero_key_table();
        start_op(32'hEEDBA521, 32'h6D8F4B15);
        wait_done(150, 0, 0, lat);
        check_eq("std_lat", lat, 103);
        check_eq("std_oA", oA, 32'h0);
        check_eq("std_oB", oB, 32'h0);

        // Back-to-back operations, start taken on the oDone cycle
        encrypt(32'h01234567, 32'h89ABCDEF, c1a, c1b);
        encrypt(32'hCAFEBABE, 32'h13579BDF, c2a, c2b);
        start_op(c1a, c1b);
        wait_done(150, 0, 0, lat);
        check_eq("v1_oA", oA, 32'h01234567);
        check_eq("v1_oB", oB, 32'h89ABCDEF);
        start_op(c2a, c2b);
        wait_done(150, 0, 0, lat);
        check_eq("b2b_lat", lat, 103);
        check_eq("v2_oA", oA, 32'hCAFEBABE);
        check_eq("v2_oB", oB, 32'h13579BDF);

        // Result holds while inputs wander in IDLE
        iA = 32'h55555555;
        iB = 32'hAAAAAAAA;
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_oA", oA, 32'hCAFEBABE);
        check_eq("hold_oB", oB, 32'h13579BDF);

        // Second start while busy must be ignored
        d0 = done_cnt;
        start_op(c1a, c1b);
        wait_done(150, 40, 1, lat);
        check_eq("busy_start_lat", lat, 103);
        check_eq("busy_start_oA", oA, 32'h01234567);
        check_eq("busy_start_oB", oB, 32'h89ABCDEF);
        repeat (3) @(posedge clk);
        #1;
        check_eq("busy_start_dones", done_cnt - d0, 1);

        // Reset in the middle of an operation
        d0 = done_cnt;
        start_op(32'hEEDBA521, 32'h6D8F4B15);
        wait_done(120, 50, 2, lat);
        check_eq("abort_no_done", lat, 0);
        check_eq("abort_dones", done_cnt - d0, 0);
        check_eq("abort_busy", 32'(oBusy), 32'd0);
        check_eq("abort_oA", oA, 32'h0);
        start_op(32'hEEDBA521, 32'h6D8F4B15);
        wait_done(150, 0, 0, lat);
        check_eq("restart_lat", lat, 103);
        check_eq("restart_oA", oA, 32'h0);
        check_eq("restart_oB", oB, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
